// File: rtl/pwm_gen.sv
// pwm_gen: single-channel free-running PWM generator.
//
// A WIDTH-bit up-counter defines a period of 2^WIDTH clk cycles. A duty value
// written by the host (en strobe + value_input) lands in a shadow register.
// It is copied to the active duty register only on the last cycle of a
// period, so a pulse is never cut short or stretched mid-period.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, highest priority
//   en           write strobe; value_input is captured on every edge with en=1
//   value_input  requested number of high cycles per period (0..2^WIDTH-1)
//   out          registered PWM output
//
// Build option:
//   PWM_INVERT_EN  when defined, out is active-low (idle/reset level 1) for
//                  driving active-low LED pads directly. Counter, shadow and
//                  duty behaviour do not change.
module pwm_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] value_input,
  output logic             out
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] duty;
  logic             wrap;
  logic             pwm_level;

  // Last cycle of the period: the only point where duty may change.
  assign wrap = (cnt == {WIDTH{1'b1}});

`ifdef PWM_INVERT_EN
  localparam logic IDLE_LEVEL = 1'b1;
  assign pwm_level = ~(cnt < duty);
`else
  localparam logic IDLE_LEVEL = 1'b0;
  assign pwm_level = (cnt < duty);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pending <= '0;
      duty    <= '0;
      out     <= IDLE_LEVEL;
    end else begin
      cnt <= cnt + 1'b1;
      if (en) begin
        pending <= value_input;
      end
      // A write on the boundary cycle bypasses the shadow so it is not
      // delayed by a whole period.
      if (wrap) begin
        duty <= en ? value_input : pending;
      end
      out <= pwm_level;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
module tb_pwm_gen;

  localparam int WIDTH = 8;
  localparam int PER   = 1 << WIDTH;
`ifdef PWM_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] value_input;
  logic             out;

  int errors = 0;
  int checks = 0;

  pwm_gen #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .value_input (value_input),
    .out         (out)
  );

  always #5 clk = ~clk;

  // Behavioural model: position in period is elapsed cycles since reset
  // modulo the period; a period's high time equals the duty that was in
  // force when it started, output delayed one cycle.
  int m_ncyc  = 0;
  int m_pos   = 0;
  int m_shad  = 0;
  int m_act   = 0;
  bit exp_out = 1'b0;
  bit chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ncyc  = 0;
      m_pos   = 0;
      m_shad  = 0;
      m_act   = 0;
      exp_out = INV;
    end else begin
      exp_out = (m_pos < m_act) ^ INV;
      if (en) m_shad = int'(value_input);
      if (m_pos == PER - 1) m_act = m_shad;
      m_ncyc = m_ncyc + 1;
      m_pos  = m_ncyc % PER;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL model_cmp t=%0t pos=%0d out=%b expected=%b", $time, m_pos, out, exp_out);
      end
    end
  end

  task automatic check_lit(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Wait (at negedge) until the counter holds pos; bounded.
  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    while (m_pos != pos && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    if (m_pos != pos) check_lit("wait_pos_timeout", m_pos, pos);
  endtask

  // Starting at a negedge with cnt=0, run one full period, counting active
  // output cycles; optionally write at two positions (-1 = no write).
  task automatic run_period(input int wp0, input int wv0, input int wp1, input int wv1,
                            output int n_act);
    n_act = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == wp0) begin
        en = 1'b1; value_input = WIDTH'(wv0);
      end else if (i == wp1) begin
        en = 1'b1; value_input = WIDTH'(wv1);
      end else begin
        en = 1'b0;
      end
      @(negedge clk);
      if (out ^ INV) n_act++;
    end
    en = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; en = 1'b0; value_input = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check_lit("reset_out", int'(out), int'(INV));
    rst = 1'b0;

    // Idle: no writes for 600 cycles.
    repeat (600) @(negedge clk);
    wait_pos(0);
    run_period(-1, 0, -1, 0, n);
    check_lit("idle_period", n, 0);

    // Write 64 at cnt=10: current period stays idle, then 64 per period.
    run_period(10, 64, -1, 0, n);
    check_lit("w64_current", n, 0);
    run_period(-1, 0, -1, 0, n);
    check_lit("w64_period1", n, 64);
    run_period(5, 255, -1, 0, n);
    check_lit("w64_period2", n, 64);

    // 255 then 0 written mid-period.
    run_period(100, 0, -1, 0, n);
    check_lit("w255_period", n, 255);
    run_period(-1, 0, -1, 0, n);
    check_lit("w0_period", n, 0);

    // Last write wins; current period unaffected.
    run_period(20, 100, 200, 30, n);
    check_lit("two_writes_current", n, 0);
    run_period(-1, 0, -1, 0, n);
    check_lit("two_writes_next", n, 30);

    // Write on the boundary cycle takes effect immediately.
    run_period(255, 128, -1, 0, n);
    check_lit("boundary_current", n, 30);
    run_period(0, 200, -1, 0, n);
    check_lit("boundary_next", n, 128);

    // Duty 200 active; reset at cnt=50 for 2 cycles.
    for (int i = 0; i < 50; i++) @(negedge clk);
    check_lit("pre_rst_pos", m_pos, 50);
    check_lit("pre_rst_out", int'(out), int'(1'b1 ^ INV));
    rst = 1'b1;
    @(negedge clk);
    check_lit("rst_out_first", int'(out), int'(INV));
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (600) begin
      @(negedge clk);
      if (out ^ INV) n++;
    end
    check_lit("post_rst_idle", n, 0);
    wait_pos(0);
    run_period(3, 16, -1, 0, n);
    check_lit("post_rst_w16_current", n, 0);
    run_period(-1, 0, -1, 0, n);
    check_lit("post_rst_w16_next", n, 16);

    // en held high continuously: duty picks the value present at the boundary.
    for (int i = 0; i < PER; i++) begin
      en = 1'b1; value_input = WIDTH'(i % 50);
      @(negedge clk);
    end
    en = 1'b0;
    run_period(-1, 0, -1, 0, n);
    check_lit("en_held", n, 255 % 50);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Single-channel, free-running PWM generator with an 8-bit default duty resolution.
- A host pulses `en` for one cycle with a duty value. The value is captured into a shadow register and applied only at the next period boundary, so the output never glitches mid-period.
- Sits between a fabric clock source (e.g. on-chip HF oscillator) and LED/pad drivers. The host typically ramps the duty value over time.

Parameters:
- WIDTH, 8, bit width of the duty value and the period counter; period = 2^WIDTH clock cycles.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  write strobe; `value_input` is sampled on every rising edge where `en`=1.
- value_input  input  WIDTH  requested duty: number of high cycles per period (0..2^WIDTH-1).
- out  output  1  registered PWM output.

Behaviour:
- Reset is synchronous, active-high, and has priority over all other logic. When `rst`=1 at a rising edge:
  - cnt=0, pending=0, duty=0.
  - `out`=0 (or 1 with PWM_INVERT_EN).
- Internal state:
  - cnt: WIDTH-bit free-running counter.
  - pending: WIDTH-bit shadow register.
  - duty: WIDTH-bit active register.
- On each rising edge with `rst`=0:
  - cnt <= cnt+1, wrapping from 2^WIDTH-1 to 0 without flags or stalls.
  - If `en`=1: pending <= value_input. Multiple writes within one period are allowed; the last one wins.
  - If cnt == 2^WIDTH-1 (period boundary): duty <= (`en` ? value_input : pending). A write on the boundary cycle itself takes effect immediately in the next period.
  - out <= (cnt < duty), an unsigned compare using the pre-edge values.
- Consequences of the update rules:
  - `out` is high for exactly `duty` cycles per period, starting at the cycle after cnt=0 (one-cycle register latency).
  - duty=0 keeps `out` constantly low.
  - duty=2^WIDTH-1 gives 2^WIDTH-1 high cycles and 1 low cycle; 100% duty is not reachable.
- Write latency: a value written while cnt=k becomes active at the next wrap. `out` reflects it from the edge after the next cnt=0, i.e. 2^WIDTH-k cycles later.
- `duty` never changes except at cnt=2^WIDTH-1, so a mid-period write cannot truncate or extend the current pulse.
- Reset asserted mid-period:
  - Pending and active duty are discarded.
  - The counter restarts at 0 on the first cycle after `rst` deasserts.
  - `out` stays at its idle level until a value is written and a period boundary passes.
- `en` held high continuously is legal. pending tracks value_input every cycle, and duty loads whatever is present on the boundary cycle.
- No X propagation: every register has a reset value and no outputs are combinational.

Optional Feature:
- Macro: PWM_INVERT_EN.
- Defined: `out` is active-low, i.e. out <= ~(cnt < duty), and the reset value of `out` is 1. This drives active-low LED pads directly.
- Undefined: `out` is active-high with reset value 0, as specified above.
- Counter, shadow and duty behaviour are identical in both builds.

Test Plan:
- Reset then no writes for 600 cycles -> `out`=0 on every cycle; with PWM_INVERT_EN, `out`=1 on every cycle.
- Write 64 with `en` at cnt=10 -> `out` stays 0 until the wrap. Then in each 256-cycle period, `out` is high for exactly 64 consecutive cycles starting one cycle after cnt=0, and low for 192.
- Write 255 -> per period 255 high, 1 low. Write 0 afterwards -> low for the whole next period after the boundary, while the current period completes unchanged.
- Mid-period writes of 100 at cnt=20 and 30 at cnt=200 -> the current period keeps its old duty; the next period has 30 high cycles (last write wins).
- Write 128 exactly on the boundary cycle (cnt=255) -> the immediately following period has 128 high cycles.
- Active duty 200, assert `rst` at cnt=50 for 2 cycles -> `out`=0 from the edge after `rst` is sampled. After release, `out` stays low indefinitely until a new write; a write of 16 then yields 16 high cycles per period after the next wrap.
